// File: rtl/vga_text_renderer.sv
// Text-mode VGA pixel generator: character/attribute buffer, raster counters,
// external font ROM lookup, and inverse/blink/cursor pixel composition.
module vga_text_renderer #(
  parameter int unsigned COLS        = 80,
  parameter int unsigned ROWS        = 30,
  parameter int unsigned CHAR_H_LOG2 = 4,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned COL_W       = 7,
  parameter int unsigned ROW_W       = 5,
  parameter int unsigned BLINK_LOG2  = 4
) (
  input  logic                     vga_clock,
  input  logic                     reset,
  input  logic                     write_enable,
  input  logic [ADDR_W-1:0]        write_address,
  input  logic [7:0]               data,
  input  logic [1:0]               attr,
  input  logic                     q_clock_enable,
  input  logic                     cursor_enable,
  input  logic [COL_W-1:0]         cursor_col,
  input  logic [ROW_W-1:0]         cursor_row,
  output logic [8+CHAR_H_LOG2-1:0] font_address,
  input  logic [7:0]               font_q,
  output logic                     q
);

  localparam int unsigned CHAR_H = 1 << CHAR_H_LOG2;
  localparam int unsigned H_MAX  = COLS * 8 - 1;
  localparam int unsigned V_MAX  = ROWS * CHAR_H - 1;
  localparam int unsigned H_W    = $clog2(COLS * 8);
  localparam int unsigned V_W    = $clog2(ROWS * CHAR_H);
  localparam int unsigned CELLS  = COLS * ROWS;

  // Stage 0: raster counters
  logic [H_W-1:0]        h_q, h_d;
  logic [V_W-1:0]        v_q, v_d;
  logic [BLINK_LOG2-1:0] frame_q, frame_d;

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (q_clock_enable) begin
      if (h_q == H_W'(H_MAX)) begin
        h_d = '0;
        if (v_q == V_W'(V_MAX)) begin
          v_d     = '0;
          frame_d = frame_q + BLINK_LOG2'(1);
        end else begin
          v_d = v_q + V_W'(1);
        end
      end else begin
        h_d = h_q + H_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
    end
  end

  logic [H_W-4:0]             cell_col;
  logic [V_W-CHAR_H_LOG2-1:0] cell_row;
  logic [CHAR_H_LOG2-1:0]     line0;
  logic [ADDR_W-1:0]          rd_addr;
  logic                       blink_phase;
  logic                       cursor_hit;

  always_comb begin
    cell_col    = h_q[H_W-1:3];
    cell_row    = v_q[V_W-1:CHAR_H_LOG2];
    line0       = v_q[CHAR_H_LOG2-1:0];
    rd_addr     = ADDR_W'(cell_row) * ADDR_W'(COLS) + ADDR_W'(cell_col);
    blink_phase = frame_q[BLINK_LOG2-1];
    cursor_hit  = cursor_enable && blink_phase
               && (32'(cell_col) == 32'(cursor_col))
               && (32'(cell_row) == 32'(cursor_row))
               && (32'(line0) >= CHAR_H - 2);
  end

  // Character/attribute buffer: {attr, code}; read-before-write on collisions
  logic [9:0] mem [CELLS];

  always_ff @(posedge vga_clock) begin
    if (!reset && write_enable && (32'(write_address) < CELLS)) begin
      mem[write_address] <= {attr, data};
    end
  end

  // Stage 1 registers: buffer read data plus sideband
  logic [9:0]             rd_q;
  logic                   val1_q, cur1_q, phase1_q;
  logic [2:0]             pix1_q;
  logic [CHAR_H_LOG2-1:0] line1_q;
  // Stage 2 registers: sideband aligned with font_q
  logic                   val2_q, cur2_q, phase2_q;
  logic [2:0]             pix2_q;
  logic [1:0]             attr2_q;
  logic                   q_q;
  logic                   pix_d;

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      rd_q     <= '0;
      val1_q   <= 1'b0;
      cur1_q   <= 1'b0;
      phase1_q <= 1'b0;
      pix1_q   <= '0;
      line1_q  <= '0;
      val2_q   <= 1'b0;
      cur2_q   <= 1'b0;
      phase2_q <= 1'b0;
      pix2_q   <= '0;
      attr2_q  <= '0;
      q_q      <= 1'b0;
    end else begin
      rd_q     <= mem[rd_addr];
      val1_q   <= 1'b1;
      cur1_q   <= cursor_hit;
      phase1_q <= blink_phase;
      pix1_q   <= h_q[2:0];
      line1_q  <= line0;
      val2_q   <= val1_q;
      cur2_q   <= cur1_q;
      phase2_q <= phase1_q;
      pix2_q   <= pix1_q;
      attr2_q  <= rd_q[9:8];
      q_q      <= val2_q & pix_d;
    end
  end

  // font_address is driven straight from stage-1 registers so the ROM's
  // one-cycle latency lands font_q in stage 2 (pixel-to-q latency of 3).
  assign font_address = {rd_q[7:0], line1_q};

  always_comb begin
    pix_d = font_q[3'd7 - pix2_q];
    if (attr2_q[1] && !phase2_q) pix_d = 1'b0;
    pix_d = pix_d ^ attr2_q[0];
    pix_d = pix_d ^ cur2_q;
  end

  assign q = q_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Self-checking bench for vga_text_renderer with a reduced raster so that
// several blink periods fit; behavioural model plus literal pin points.
module tb_vga_text_renderer;
  localparam int COLS = 4, ROWS = 3, CHL = 2, ADDR_W = 4, COL_W = 3, ROW_W = 2, BL = 2;
  localparam int CH = 1 << CHL, W = COLS * 8, H = ROWS * CH, CELLS = COLS * ROWS;
  localparam int FA_W = 8 + CHL;

  logic clk = 1'b0;
  logic reset = 1'b1, we = 1'b0, qce = 1'b0, cen = 1'b0;
  logic [ADDR_W-1:0] wa = '0;
  logic [7:0] data = '0;
  logic [1:0] attr = '0;
  logic [COL_W-1:0] ccol = '0;
  logic [ROW_W-1:0] crow = '0;
  logic [FA_W-1:0] font_address;
  logic [7:0] font_q;
  logic q;

  always #5 clk = ~clk;

  vga_text_renderer #(
    .COLS(COLS), .ROWS(ROWS), .CHAR_H_LOG2(CHL), .ADDR_W(ADDR_W),
    .COL_W(COL_W), .ROW_W(ROW_W), .BLINK_LOG2(BL)
  ) dut (
    .vga_clock(clk), .reset(reset), .write_enable(we), .write_address(wa),
    .data(data), .attr(attr), .q_clock_enable(qce), .cursor_enable(cen),
    .cursor_col(ccol), .cursor_row(crow), .font_address(font_address),
    .font_q(font_q), .q(q)
  );

  // Font ROM: blank glyph 0, line 0 of any glyph equals its code
  function automatic logic [7:0] glyph(input int c, input int l);
    if (c == 0) return 8'h00;
    return 8'(c ^ (l * 'h35));
  endfunction

  always @(posedge clk) font_q <= glyph(int'(font_address[FA_W-1:CHL]), int'(font_address[CHL-1:0]));

  // Behavioural model: linear raster position, shadow buffer, delay lines
  int shadow [CELLS];
  int mpos = 0, mf = 0;
  int qp [3] = '{0, 0, 0};
  int tp [3] = '{-1, -1, -1};
  int efa = 0, ftag = -1;
  bit chk_on = 1'b0;
  int n_cmp = 0, n_bad = 0;

  function automatic int tag(input int f, input int v, input int h);
    return f * 1000000 + v * 1000 + h;
  endfunction

  function automatic int pixel(input int pos, input int f);
    int h, v, col, row, line, e, p, ph;
    h = pos % W; v = pos / W;
    col = h / 8; row = v / CH; line = v % CH;
    e = shadow[row * COLS + col];
    ph = (f >> (BL - 1)) & 1;
    p = (glyph(e & 255, line) >> (7 - h % 8)) & 1;
    if (((e >> 9) & 1) == 1 && ph == 0) p = 0;
    if (((e >> 8) & 1) == 1) p = p ^ 1;
    if (cen && ph == 1 && col == int'(ccol) && row == int'(crow) && line >= CH - 2) p = p ^ 1;
    return p;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mpos <= 0; mf <= 0;
      qp <= '{0, 0, 0}; tp <= '{-1, -1, -1};
      efa <= 0; ftag <= -1;
    end else begin
      qp[0] <= pixel(mpos, mf); qp[1] <= qp[0]; qp[2] <= qp[1];
      tp[0] <= tag(mf, mpos / W, mpos % W); tp[1] <= tp[0]; tp[2] <= tp[1];
      efa <= ((shadow[(mpos / W / CH) * COLS + (mpos % W) / 8] & 255) << CHL) | ((mpos / W) % CH);
      ftag <= tag(mf, mpos / W, mpos % W);
      if (qce) begin
        if (mpos == W * H - 1) begin
          mpos <= 0;
          mf <= (mf + 1) % (1 << BL);
        end else begin
          mpos <= mpos + 1;
        end
      end
      if (we && int'(wa) < CELLS) shadow[wa] <= (int'(attr) << 8) | int'(data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Literal pin points, keyed by the raster tag of the pixel they describe
  int    lit_tag [$];
  bit    lit_fa  [$];
  int    lit_val [$];
  string lit_name[$];

  always @(negedge clk) begin
    if (chk_on) begin
      check("q", 32'(q), 32'(qp[2]));
      check("font_address", 32'(font_address), 32'(efa));
      for (int i = lit_tag.size() - 1; i >= 0; i--) begin
        if (lit_tag[i] == (lit_fa[i] ? ftag : tp[2])) begin
          if (lit_fa[i]) check(lit_name[i], 32'(font_address), 32'(lit_val[i]));
          else           check(lit_name[i], 32'(q), 32'(lit_val[i]));
          lit_tag.delete(i); lit_fa.delete(i); lit_val.delete(i); lit_name.delete(i);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic add_lit(input int f, input int v, input int h, input bit is_fa, input int val, input string name);
    lit_tag.push_back(tag(f, v, h)); lit_fa.push_back(is_fa);
    lit_val.push_back(val); lit_name.push_back(name);
  endtask

  task automatic lits_done(input string name);
    n_cmp++;
    if (lit_tag.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d pin points never reached, expected 0", name, lit_tag.size());
      lit_tag.delete(); lit_fa.delete(); lit_val.delete(); lit_name.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; qce = 1'b1; we = 1'b0;
    repeat (2) tick();
    reset = 1'b0; qce = 1'b0;
  endtask

  task automatic wr(input int a, input int at, input int d);
    we = 1'b1; wa = ADDR_W'(a); attr = 2'(at); data = 8'(d);
    tick();
    we = 1'b0;
  endtask

  task automatic run(input int n);
    qce = 1'b1;
    repeat (n) tick();
  endtask

  localparam int FRAME = W * H;

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    for (int a = 0; a < CELLS; a++) wr(a, 0, 0);

    // Reset with enable high: outputs stay 0 through reset and 3 cycles after
    reset = 1'b1; qce = 1'b1;
    tick();
    chk_on = 1'b1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_fa", 32'(font_address), 32'd0);
    repeat (2) begin
      tick();
      check("rst_q", 32'(q), 32'd0);
      check("rst_fa", 32'(font_address), 32'd0);
    end
    reset = 1'b0;
    repeat (3) begin
      tick();
      check("rst_hold_q", 32'(q), 32'd0);
      check("rst_hold_fa", 32'(font_address), 32'd0);
    end

    // Plain glyph 0x41 at row 2 col 1; illegal addresses are ignored
    do_reset();
    wr(9, 0, 'h41); wr(12, 3, 'hFF); wr(15, 3, 'h77);
    add_lit(0, 8, 8, 1'b1, 'h104, "fa_r2c1_l0");
    add_lit(0, 11, 12, 1'b1, 'h107, "fa_r2c1_l3");
    add_lit(0, 8, 8, 1'b0, 0, "plain_h8");
    add_lit(0, 8, 9, 1'b0, 1, "plain_h9");
    add_lit(0, 8, 15, 1'b0, 1, "plain_h15");
    add_lit(0, 11, 8, 1'b0, 1, "plain_l3_h8");
    add_lit(0, 11, 15, 1'b0, 0, "plain_l3_h15");
    run(FRAME + 50);
    // Stall mid-line: counters hold, q settles on the held pixel
    qce = 1'b0;
    repeat (10) tick();
    run(40);
    lits_done("plain_pins");

    // Inverse attribute
    do_reset();
    wr(9, 1, 'h41);
    add_lit(0, 8, 8, 1'b0, 1, "inv_h8");
    add_lit(0, 8, 9, 1'b0, 0, "inv_h9");
    add_lit(0, 11, 15, 1'b0, 1, "inv_l3_h15");
    run(FRAME + 50);
    lits_done("inv_pins");

    // Blink attribute: dark while blink phase is 0, glyph while it is 1
    do_reset();
    wr(9, 2, 'h41);
    add_lit(0, 8, 9, 1'b0, 0, "blink_f0_h9");
    add_lit(0, 8, 15, 1'b0, 0, "blink_f0_h15");
    add_lit(2, 8, 9, 1'b0, 1, "blink_f2_h9");
    add_lit(2, 8, 15, 1'b0, 1, "blink_f2_h15");
    run(3 * FRAME + 50);
    lits_done("blink_pins");

    // Cursor over a blank cell, bottom two glyph lines only
    do_reset();
    wr(9, 0, 0);
    cen = 1'b1; ccol = 3'd1; crow = 2'd2;
    add_lit(0, 11, 8, 1'b0, 0, "cur_f0_l3");
    add_lit(2, 11, 8, 1'b0, 1, "cur_f2_l3");
    add_lit(2, 10, 15, 1'b0, 1, "cur_f2_l2");
    add_lit(2, 9, 8, 1'b0, 0, "cur_f2_l1");
    add_lit(2, 11, 16, 1'b0, 0, "cur_f2_nextcol");
    run(3 * FRAME + 50);
    lits_done("cursor_pins");

    // Cursor over an inverse blank cell cancels to 0
    do_reset();
    wr(9, 1, 0);
    add_lit(2, 11, 8, 1'b0, 0, "curinv_l3");
    add_lit(2, 9, 8, 1'b0, 1, "curinv_l1");
    run(3 * FRAME + 50);
    lits_done("curinv_pins");

    // Randomised traffic against the model
    for (int i = 0; i < 15000; i++) begin
      we   = ($urandom_range(0, 5) == 0);
      wa   = ADDR_W'($urandom_range(0, 15));
      data = 8'($urandom);
      attr = 2'($urandom);
      qce  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 299) == 0) begin
        cen  = ($urandom_range(0, 3) != 0);
        ccol = COL_W'($urandom_range(0, COLS - 1));
        crow = ROW_W'($urandom_range(0, ROWS - 1));
      end
      reset = ($urandom_range(0, 2999) == 0);
      tick();
    end
    reset = 1'b0; we = 1'b0;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
